// File: rtl/slot_pkg.sv
// Shared types and default sizes for the slot machine reel datapath.
// The game FSM's state encoding and the reel sequencer's own state live here.
package slot_pkg;

    typedef enum logic [1:0] {
        SET  = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        WIN  = 2'b11
    } fsm_state_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPIN    = 3'd1,
        STAGGER = 3'd2,
        EVAL    = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam int DEF_SYMBOL_W  = 3;
    localparam int DEF_NUM_REELS = 3;

endpackage

// File: rtl/slot_reel.sv
// One reel: a symbol counter that advances by STEP on each spin tick while running.
// Stop beats start, and start beats tick, so a reel never moves on the edge it stops.
module slot_reel #(
    parameter int SYMBOL_W = 3,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    input  logic                i_start,
    input  logic                i_stop,
    output logic [SYMBOL_W-1:0] o_sym,
    output logic                o_stopped
);

    localparam logic [SYMBOL_W-1:0] STEP_V = SYMBOL_W'(STEP);

    logic [SYMBOL_W-1:0] r_sym;
    logic                r_stopped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym     <= '0;
            r_stopped <= 1'b1;
        end else if (i_stop) begin
            r_stopped <= 1'b1;
        end else if (i_start) begin
            r_stopped <= 1'b0;
        end else if (i_tick && !r_stopped) begin
            r_sym <= r_sym + STEP_V;
        end
    end

    assign o_sym     = r_sym;
    assign o_stopped = r_stopped;

endmodule

// File: rtl/slot_reel_sequencer.sv
// Reel datapath controller: follows the game state, spins the reels, stops them one by one
// at a fixed gap, then compares the stopped symbols and reports a win.
module slot_reel_sequencer
    import slot_pkg::*;
#(
    parameter int NUM_REELS = DEF_NUM_REELS,
    parameter int SYMBOL_W  = DEF_SYMBOL_W,
    parameter int SPIN_DIV  = 4,
    parameter int STOP_GAP  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    state,
    output logic [NUM_REELS*SYMBOL_W-1:0] reel_sym,
    output logic [NUM_REELS-1:0]          reel_stopped,
    output logic                          spin_done,
    output logic                          win_flag,
    output seq_state_t                    seq_dbg
);

    localparam int PRESC_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
    localparam int GAP_W   = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
    localparam int IDX_W   = $clog2(NUM_REELS + 1);

    seq_state_t         r_seq;
    logic [PRESC_W-1:0] r_presc;
    logic [GAP_W-1:0]   r_gap;
    logic [IDX_W-1:0]   r_idx;
    logic               r_spin_done;
    logic               r_win;

    fsm_state_t          w_state;
    logic                w_active;
    logic                w_abort;
    logic                w_tick;
    logic                w_start;
    logic                w_first_stop;
    logic                w_gap_wrap;
    logic                w_gap_stop;
    logic                w_last_idx;
    logic [PRESC_W-1:0]  w_presc_next;
    logic [GAP_W-1:0]    w_gap_next;
    logic [NUM_REELS-1:0] w_stop;
    logic [SYMBOL_W-1:0] w_sym [NUM_REELS];
    logic                w_all_eq;

    assign w_state      = fsm_state_t'(state);
    assign w_active     = (r_seq == SPIN) || (r_seq == STAGGER);
    assign w_abort      = w_active && (w_state == SET);
    assign w_tick       = w_active && !w_abort && (r_presc == PRESC_W'(SPIN_DIV - 1));
    assign w_start      = (r_seq == IDLE) && (w_state == RUN);
    assign w_first_stop = (r_seq == SPIN) && (w_state == STOP);
    assign w_gap_wrap   = (r_gap == GAP_W'(STOP_GAP - 1));
    assign w_gap_stop   = (r_seq == STAGGER) && !w_abort && w_gap_wrap;
    assign w_last_idx   = (r_idx == IDX_W'(NUM_REELS - 1));
    assign w_presc_next = (r_presc == PRESC_W'(SPIN_DIV - 1)) ? '0 : r_presc + PRESC_W'(1);
    assign w_gap_next   = w_gap_wrap ? '0 : r_gap + GAP_W'(1);

    // Reel i spins with step 2i+1, so reels drift apart between stops.
    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        if (i == 0) begin : g_first
            assign w_stop[i] = w_abort || w_first_stop;
        end else begin : g_rest
            assign w_stop[i] = w_abort || (w_gap_stop && (r_idx == IDX_W'(i)));
        end

        slot_reel #(
            .SYMBOL_W (SYMBOL_W),
            .STEP     (2 * i + 1)
        ) u_reel (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (w_tick),
            .i_start   (w_start),
            .i_stop    (w_stop[i]),
            .o_sym     (w_sym[i]),
            .o_stopped (reel_stopped[i])
        );

        assign reel_sym[i*SYMBOL_W +: SYMBOL_W] = w_sym[i];
    end

    always_comb begin
        w_all_eq = 1'b1;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (w_sym[i] != w_sym[0]) w_all_eq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq       <= IDLE;
            r_presc     <= '0;
            r_gap       <= '0;
            r_idx       <= '0;
            r_spin_done <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            case (r_seq)
                IDLE: begin
                    if (w_state == RUN) begin
                        r_seq       <= SPIN;
                        r_presc     <= '0;
                        r_spin_done <= 1'b0;
                        r_win       <= 1'b0;
                    end
                end
                SPIN: begin
                    if (w_abort) begin
                        r_seq       <= IDLE;
                        r_spin_done <= 1'b0;
                        r_win       <= 1'b0;
                    end else begin
                        r_presc <= w_presc_next;
                        if (w_state == STOP) begin
                            r_seq <= (NUM_REELS == 1) ? EVAL : STAGGER;
                            r_idx <= IDX_W'(1);
                            r_gap <= '0;
                        end
                    end
                end
                STAGGER: begin
                    if (w_abort) begin
                        r_seq       <= IDLE;
                        r_spin_done <= 1'b0;
                        r_win       <= 1'b0;
                    end else begin
                        r_presc <= w_presc_next;
                        r_gap   <= w_gap_next;
                        if (w_gap_wrap) begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (w_last_idx) r_seq <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    r_win       <= w_all_eq;
                    r_spin_done <= 1'b1;
                    r_seq       <= DONE;
                end
                DONE: begin
                    if (w_state == SET) begin
                        r_seq       <= IDLE;
                        r_spin_done <= 1'b0;
                        r_win       <= 1'b0;
                    end
                end
                default: r_seq <= IDLE;
            endcase
        end
    end

    assign spin_done = r_spin_done;
    assign win_flag  = r_win;
    assign seq_dbg   = r_seq;

endmodule
